// File: rtl/rsp_vote_collector_pkg.sv
// Shared types and helpers for the response vote collector: FSM state encoding,
// default response width and a constant-foldable ceil(log2) used to size counters.
package rsp_vote_collector_pkg;

    localparam int RSP_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_ACC      = 3'd3,
        ST_GAP      = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // Bits needed to hold values 0..value-1; bounded loop so it folds at elaboration.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rsp_vote_collector_bit_counter.sv
// One response-bit slice: counts evaluations in which the bit was 1 and reports
// majority/stability of the count as it will be after the current increment.
module rsp_vote_collector_bit_counter
    import rsp_vote_collector_pkg::*;
#(
    parameter int NUM_EVAL = 7,
    parameter int CW       = clog2(NUM_EVAL + 1)
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic inc_en,
    input  logic bit_in,
    output logic majority,
    output logic stable
);

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    // Votes look at the post-increment value so the final evaluation is included
    // in the same cycle it is accumulated.
    always_comb begin
        count_next = count + CW'(inc_en & bit_in);
        majority   = (count_next > CW'(NUM_EVAL / 2));
        stable     = (count_next == '0) || (count_next == CW'(NUM_EVAL));
    end

    always_ff @(posedge clk) begin
        if (!resetn || clear) count <= '0;
        else                  count <= count_next;
    end

endmodule

// File: rtl/rsp_vote_collector.sv
// Requests NUM_EVAL evaluations of one challenge from rwc_ctrl, votes each bit of
// rsp_pos^rsp_neg and hands the majority response plus stability mask off via valid/ready.
module rsp_vote_collector
    import rsp_vote_collector_pkg::*;
#(
    parameter int RSP_W      = RSP_W_DEF,
    parameter int NUM_EVAL   = 7,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    output logic             eval_req,
    input  logic             available,
    input  logic [RSP_W-1:0] rsp_pos,
    input  logic [RSP_W-1:0] rsp_neg,
    output logic             busy,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RSP_W-1:0] rsp_data,
    output logic [RSP_W-1:0] rsp_stable,
    output logic             timeout_err,
    output state_t           dbg_state
);

    localparam int TW = clog2(TIMEOUT + 1);
    localparam int GW = clog2(GAP_CYCLES + 1);

    if ((NUM_EVAL % 2) == 0 || NUM_EVAL < 1 || NUM_EVAL > 255 || GAP_CYCLES < 1 || TIMEOUT < 2) begin : g_bad_param
        $error("rsp_vote_collector: NUM_EVAL must be odd in 1..255, GAP_CYCLES>=1, TIMEOUT>=2");
    end

    // Result handshake: rsp_valid rises on entry to DONE and holds rsp_data/rsp_stable
    // unchanged until the cycle where rsp_valid && rsp_ready, which is the transfer.
    state_t           state, state_n;
    logic [7:0]       eval_cnt;
    logic [TW-1:0]    to_cnt, to_cnt_inc;
    logic [GW-1:0]    gap_cnt;
    logic [RSP_W-1:0] raw;
    logic [RSP_W-1:0] vote_data, vote_stable;
    logic             acc_last, timeout_hit, clear_cnt, inc_en;

    assign acc_last   = (eval_cnt == 8'(NUM_EVAL - 1));
    assign to_cnt_inc = to_cnt + 1'b1;
    assign clear_cnt  = (state == ST_IDLE) && start;
    assign inc_en     = (state == ST_ACC);
    assign busy       = (state != ST_IDLE);
    assign dbg_state  = state;

    for (genvar i = 0; i < RSP_W; i++) begin : g_bit
        rsp_vote_collector_bit_counter #(.NUM_EVAL(NUM_EVAL)) u_bit (
            .clk      (clk),
            .resetn   (resetn),
            .clear    (clear_cnt),
            .inc_en   (inc_en),
            .bit_in   (raw[i]),
            .majority (vote_data[i]),
            .stable   (vote_stable[i])
        );
    end

    always_comb begin
        state_n     = state;
        eval_req    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: if (start) state_n = ST_REQ;
            // A level-style available left over from the previous evaluation must fall first.
            ST_REQ: begin
                if (!available) begin
                    eval_req = 1'b1;
                    state_n  = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (available) begin
                    state_n = ST_ACC;
                end else if (to_cnt_inc == TW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_n     = ST_IDLE;
                end
            end
            ST_ACC:  state_n = acc_last ? ST_DONE : ST_GAP;
            ST_GAP:  if (gap_cnt == GW'(GAP_CYCLES - 1)) state_n = ST_REQ;
            ST_DONE: if (rsp_ready) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            eval_cnt    <= '0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
            raw         <= '0;
            rsp_data    <= '0;
            rsp_stable  <= '0;
            rsp_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        eval_cnt    <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                ST_REQ: if (!available) to_cnt <= '0;
                ST_WAIT_RSP: begin
                    if (available) begin
                        raw <= rsp_pos ^ rsp_neg;
                    end else begin
                        to_cnt <= to_cnt_inc;
                        if (timeout_hit) timeout_err <= 1'b1;
                    end
                end
                ST_ACC: begin
                    eval_cnt <= eval_cnt + 1'b1;
                    gap_cnt  <= '0;
                    if (acc_last) begin
                        rsp_data   <= vote_data;
                        rsp_stable <= vote_stable;
                        rsp_valid  <= 1'b1;
                    end
                end
                ST_GAP:  gap_cnt <= gap_cnt + 1'b1;
                ST_DONE: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsp_vote_collector.sv
// Bench for rsp_vote_collector: table-driven collections against a counting vote model,
// plus hand-written timeout, backpressure, reset-abort and single-evaluation sequences.
module tb_rsp_vote_collector;
    import rsp_vote_collector_pkg::*;

    localparam int W   = 32;
    localparam int NE  = 7;
    localparam int GAP = 16;
    localparam int TO  = 64;

    typedef logic [W-1:0] word_arr_t [NE];
    typedef struct {
        word_arr_t  pos;
        word_arr_t  neg;
        int         delay;
        int         hold;
        int         ready_wait;
        bit         start_with_ready;
        logic [W-1:0] exp_data;
        logic [W-1:0] exp_stable;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic         resetn = 1'b0, start = 1'b0, available, rsp_ready = 1'b0;
    logic [W-1:0] rsp_pos, rsp_neg, rsp_data, rsp_stable;
    logic         eval_req, busy, rsp_valid, timeout_err;
    state_t       dbg_state;

    rsp_vote_collector #(.RSP_W(W), .NUM_EVAL(NE), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .clk(clk), .resetn(resetn), .start(start), .eval_req(eval_req), .available(available),
        .rsp_pos(rsp_pos), .rsp_neg(rsp_neg), .busy(busy), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_stable(rsp_stable),
        .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // Single-evaluation instance for the NUM_EVAL==1 boundary.
    logic         start1 = 1'b0, avail1, ready1 = 1'b0;
    logic [W-1:0] pos1 = '0, neg1 = '0, data1, stable1;
    logic         eval_req1, busy1, valid1, terr1;
    state_t       dbg_state1;

    rsp_vote_collector #(.RSP_W(W), .NUM_EVAL(1), .GAP_CYCLES(1), .TIMEOUT(8)) dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .eval_req(eval_req1), .available(avail1),
        .rsp_pos(pos1), .rsp_neg(neg1), .busy(busy1), .rsp_valid(valid1),
        .rsp_ready(ready1), .rsp_data(data1), .rsp_stable(stable1),
        .timeout_err(terr1), .dbg_state(dbg_state1)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference vote: count ones per bit over all evaluations.
    task automatic model(input word_arr_t p, input word_arr_t n,
                         output logic [W-1:0] d, output logic [W-1:0] s);
        for (int b = 0; b < W; b++) begin
            int ones = 0;
            for (int e = 0; e < NE; e++) ones += int'(p[e][b] ^ n[e][b]);
            d[b] = (2 * ones > NE);
            s[b] = (ones == 0) || (ones == NE);
        end
    endtask

    // ---------------- responder driver (main instance) ----------------
    word_arr_t pos_tab, neg_tab;
    int resp_delay = 1, resp_hold = 1;
    bit mute = 1'b0;
    int req_count = 0, last_req_cyc = 0, min_gap = 1000, cur_idx = 0;
    int wait_left = 0, hold_left = 0, avail_rise_cyc = 0;
    bit valid_seen = 1'b0;

    initial begin
        available = 1'b0;
        rsp_pos   = '0;
        rsp_neg   = '0;
        forever begin
            @(negedge clk);
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) available = 1'b0;
            end
            if (wait_left > 0) begin
                wait_left--;
                if (wait_left == 0) begin
                    available      = 1'b1;
                    rsp_pos        = pos_tab[cur_idx % NE];
                    rsp_neg        = neg_tab[cur_idx % NE];
                    hold_left      = resp_hold;
                    avail_rise_cyc = cyc;
                end
            end
            #1;
            if (eval_req && resetn) begin
                if (req_count > 0 && (cyc - last_req_cyc) < min_gap) min_gap = cyc - last_req_cyc;
                last_req_cyc = cyc;
                cur_idx      = req_count;
                req_count++;
                if (!mute) wait_left = resp_delay;
            end
        end
    end

    always @(negedge clk) if (rsp_valid) valid_seen = 1'b1;

    // Single-eval responder: one-cycle available in the cycle after eval_req1.
    bit req_seen1 = 1'b0;
    initial begin
        avail1 = 1'b0;
        forever begin
            @(negedge clk);
            avail1 = req_seen1;
            #1 req_seen1 = eval_req1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_collection(input vec_t v, input string tag);
        int n;
        logic [W-1:0] d0, s0;
        bit held;
        pos_tab = v.pos;  neg_tab = v.neg;
        resp_delay = v.delay;  resp_hold = v.hold;
        mute = 1'b0;  req_count = 0;  min_gap = 1000;
        @(negedge clk);
        pulse_start();
        check({tag, "_busy"}, W'(busy), W'(1));
        check({tag, "_terr_clr"}, W'(timeout_err), W'(0));
        n = 0;
        while (!rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_bound"}, W'(rsp_valid), W'(1));
        check({tag, "_latency"}, W'(cyc - avail_rise_cyc), W'(2));
        check({tag, "_data"}, rsp_data, v.exp_data);
        check({tag, "_stable"}, rsp_stable, v.exp_stable);
        check({tag, "_req_count"}, W'(req_count), W'(NE));
        check({tag, "_req_gap"}, W'(min_gap >= GAP), W'(1));
        if (v.ready_wait > 0) begin
            d0 = rsp_data;  s0 = rsp_stable;  held = 1'b1;
            for (int i = 0; i < v.ready_wait; i++) begin
                start = (i == 3);
                @(negedge clk);
                if (!rsp_valid || rsp_data !== d0 || rsp_stable !== s0 || !busy) held = 1'b0;
            end
            start = 1'b0;
            check({tag, "_hold_stable"}, W'(held), W'(1));
        end
        rsp_ready = 1'b1;
        start     = v.start_with_ready;
        @(negedge clk);
        rsp_ready = 1'b0;
        start     = 1'b0;
        check({tag, "_accepted"}, W'(rsp_valid), W'(0));
        check({tag, "_idle_after"}, W'(busy), W'(0));
    endtask

    // ---------------- test sequence ----------------
    vec_t tab[$];
    vec_t v;
    int   t0, n;

    initial begin
        // Directed table entries with hand-derived expectations.
        for (int e = 0; e < NE; e++) begin
            v.pos[e] = 32'hFFFF_FFFF;  v.neg[e] = 32'h0F0F_0F0F;
        end
        v.delay = 1;  v.hold = 1;  v.ready_wait = 0;  v.start_with_ready = 1'b0;
        v.exp_data = 32'hF0F0_F0F0;  v.exp_stable = 32'hFFFF_FFFF;
        tab.push_back(v);

        for (int e = 0; e < NE; e++) begin
            v.neg[e] = 32'hC3C3_0000;  v.pos[e] = 32'hC3C3_0000 ^ ((e < 4) ? 32'h1 : 32'h0);
        end
        v.delay = 3;  v.exp_data = 32'h0000_0001;  v.exp_stable = 32'hFFFF_FFFE;
        tab.push_back(v);

        for (int e = 0; e < NE; e++) begin
            v.neg[e] = 32'h7878_7878;
            v.pos[e] = 32'h7878_7878 ^ ((e < 3) ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A);
        end
        v.delay = 2;  v.hold = 10;  v.exp_data = 32'h5A5A_5A5A;  v.exp_stable = 32'h0;
        tab.push_back(v);

        for (int e = 0; e < NE; e++) begin
            v.neg[e] = 32'h0;  v.pos[e] = (e < 6) ? 32'hFFFF_0000 : 32'h0000_FFFF;
        end
        v.delay = 1;  v.hold = 30;  v.exp_data = 32'hFFFF_0000;  v.exp_stable = 32'h0;
        tab.push_back(v);

        for (int e = 0; e < NE; e++) begin
            v.neg[e] = 32'h0;  v.pos[e] = (e % 2 == 0) ? 32'h0000_00FF : 32'h0;
        end
        v.hold = 1;  v.ready_wait = 20;  v.start_with_ready = 1'b1;
        v.exp_data = 32'h0000_00FF;  v.exp_stable = 32'hFFFF_FF00;
        tab.push_back(v);

        // Randomized entries: a base word with sparse per-eval noise so both stable and
        // unstable bits appear; expectations come from the vote model.
        for (int k = 0; k < 6; k++) begin
            logic [W-1:0] base, noise;
            base  = $urandom;
            noise = $urandom & $urandom & $urandom;
            for (int e = 0; e < NE; e++) begin
                v.neg[e] = $urandom;
                v.pos[e] = v.neg[e] ^ base ^ (noise & $urandom);
            end
            v.delay = $urandom_range(1, 8);
            v.hold  = ($urandom_range(0, 3) == 0) ? 25 : $urandom_range(1, 3);
            v.ready_wait = $urandom_range(0, 4);
            v.start_with_ready = $urandom_range(0, 1);
            model(v.pos, v.neg, v.exp_data, v.exp_stable);
            tab.push_back(v);
        end

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_valid", W'(rsp_valid), W'(0));
        check("rst_eval_req", W'(eval_req), W'(0));
        check("rst_terr", W'(timeout_err), W'(0));
        check("rst_data", rsp_data, W'(0));
        check("rst_stable", rsp_stable, W'(0));
        resetn = 1'b1;
        @(negedge clk);

        foreach (tab[i]) run_collection(tab[i], $sformatf("vec%0d", i));

        // Timeout: responder silent.
        mute = 1'b1;  req_count = 0;  valid_seen = 1'b0;
        pulse_start();
        n = 0;
        while (req_count == 0 && n < 100) begin @(negedge clk); n++; end
        check("to_req_seen", W'(req_count > 0), W'(1));
        t0 = last_req_cyc;
        n = 0;
        while (!timeout_err && n < 200) begin @(negedge clk); n++; end
        check("to_latency", W'(cyc - t0), W'(TO));
        check("to_busy", W'(busy), W'(0));
        check("to_no_valid", W'(valid_seen), W'(0));
        mute = 1'b0;
        run_collection(tab[0], "after_to");

        // Reset during the 4th WAIT_RSP, then a clean collection.
        for (int e = 0; e < NE; e++) begin
            pos_tab[e] = 32'hFFFF_FFFF;  neg_tab[e] = 32'h0;
        end
        resp_delay = 8;  resp_hold = 1;  req_count = 0;  valid_seen = 1'b0;
        pulse_start();
        n = 0;
        while (req_count < 4 && n < 1000) begin @(negedge clk); n++; end
        check("rr_reached_4th", W'(req_count), W'(4));
        resetn = 1'b0;
        @(negedge clk);
        check("rr_busy", W'(busy), W'(0));
        check("rr_valid", W'(rsp_valid), W'(0));
        check("rr_eval_req", W'(eval_req), W'(0));
        check("rr_data", rsp_data, W'(0));
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        check("rr_no_partial", W'(valid_seen), W'(0));
        for (int e = 0; e < NE; e++) begin
            v.pos[e] = (e < 3) ? 32'hFFFF_FFFF : 32'h0;  v.neg[e] = 32'h0;
        end
        v.delay = 2;  v.hold = 1;  v.ready_wait = 0;  v.start_with_ready = 1'b0;
        v.exp_data = 32'h0;  v.exp_stable = 32'h0;
        run_collection(v, "after_rst");

        // NUM_EVAL==1: result equals the single raw, every bit stable.
        for (int k = 0; k < 3; k++) begin
            pos1 = $urandom;  neg1 = $urandom;
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            n = 0;
            while (!valid1 && n < 50) begin @(negedge clk); n++; end
            check($sformatf("one%0d_valid", k), W'(valid1), W'(1));
            check($sformatf("one%0d_data", k), data1, pos1 ^ neg1);
            check($sformatf("one%0d_stable", k), stable1, 32'hFFFF_FFFF);
            ready1 = 1'b1;
            @(negedge clk);
            ready1 = 1'b0;
            check($sformatf("one%0d_idle", k), W'(busy1), W'(0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

endmodule
